// File: rtl/font_pkg.sv
// Shared font definitions: glyph geometry defaults, client-id width helper and response tag type.
// Used by the font ROM arbiter and the VGA controllers.
package font_pkg;

  // Id width that stays at least one bit even for a single- or two-entry space.
  function automatic int font_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int FNT_W_DEF         = 4;
  localparam int FNT_H_DEF         = 8;
  localparam int FNT_C_DEF         = 16;
  localparam int FNT_ADDR_SIZE_DEF = $clog2(FNT_H_DEF * FNT_C_DEF);
  localparam int FNT_N_REQ_DEF     = 3;
  localparam int IDW               = font_idw(FNT_N_REQ_DEF);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } font_tag_t;

endpackage

// File: rtl/font_rr_pick.sv
// Masked priority picker for the low-priority font clients: first request at or above ptr wins,
// otherwise the lowest requesting index. Bit 0 (display fetch) is never picked here.
module font_rr_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [N_REQ-1:0] at_or_above;
  logic [N_REQ-1:0] low_req;
  logic [N_REQ-1:0] masked_req;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      if (gi == 0) begin : g_disp
        assign at_or_above[gi] = 1'b0;
      end else begin : g_low
        assign at_or_above[gi] = (ID_W'(gi) >= ptr);
      end
    end
  endgenerate

  assign low_req    = req & ~N_REQ'(1);
  assign masked_req = low_req & at_or_above;

  // x & -x isolates the lowest set bit; fall back to the unmasked set when nothing sits above ptr.
  assign gnt = (|masked_req) ? (masked_req & (~masked_req + N_REQ'(1)))
                             : (low_req & (~low_req + N_REQ'(1)));

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among N_REQ clients; client 0 (display fetch) has absolute priority.
// Define FONT_ARB_RR_EN for round-robin among clients 1..N_REQ-1, otherwise lowest index wins.
module font_rom_arbiter
  import font_pkg::*;
#(
  parameter int N_REQ     = FNT_N_REQ_DEF,
  parameter int ADDR_SIZE = FNT_ADDR_SIZE_DEF,
  parameter int FNT_W     = FNT_W_DEF,
  parameter int ROM_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0][ADDR_SIZE-1:0] addr,
  output logic [N_REQ-1:0]                gnt,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [FNT_W-1:0]                rsp_data,
  output logic                            rom_clk,
  output logic [ADDR_SIZE-1:0]            rom_addr,
  input  logic [FNT_W-1:0]                rom_q
);

  localparam int ID_W  = font_idw(N_REQ);
  localparam int DEPTH = ROM_LAT + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [N_REQ-1:0]     low_req;
  logic [N_REQ-1:0]     low_gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [ADDR_SIZE-1:0] rom_addr_reg;
  tag_t                 tag_pipe_reg [DEPTH];
  tag_t                 tag_tail;
  logic [N_REQ-1:0]     tail_onehot;
  logic [N_REQ-1:0]     rsp_valid_reg;
  logic [FNT_W-1:0]     rsp_data_reg;

  assign low_req = req & ~N_REQ'(1);

`ifdef FONT_ARB_RR_EN
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;

  font_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req (low_req),
    .ptr (ptr_reg),
    .gnt (low_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= ID_W'(1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Pointer only moves on low-client grants and never wraps onto the display client.
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_any && !gnt[0]) begin
      ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? ID_W'(1) : gnt_id + ID_W'(1);
    end
  end
`else
  assign low_gnt = low_req & (~low_req + N_REQ'(1));
`endif

  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt = req[0] ? N_REQ'(1) : low_gnt;
    end
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id = ID_W'(i);
      end
    end
  end

  assign gnt_any = |gnt;

  // Tag pipeline tracks which client owns the ROM word arriving ROM_LAT cycles after rom_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_reg <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tag_pipe_reg[s] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rom_addr_reg <= addr[gnt_id];
      end
      tag_pipe_reg[0] <= '{valid: gnt_any, id: gnt_id};
      for (int s = 1; s < DEPTH; s++) begin
        tag_pipe_reg[s] <= tag_pipe_reg[s-1];
      end
    end
  end

  assign tag_tail = tag_pipe_reg[DEPTH-1];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_dec
      assign tail_onehot[gi] = tag_tail.valid && (tag_tail.id == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= tail_onehot;
      if (tag_tail.valid) begin
        rsp_data_reg <= rom_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rom_addr  = rom_addr_reg;
  assign rom_clk   = clk;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: a ROM_LAT=1 and a ROM_LAT=2 instance share the same stimulus.
module tb_font_rom_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req = '0;
  logic [N-1:0][AW-1:0] addr = '0;

  logic [N-1:0]  gnt1, vld1, gnt2, vld2;
  logic [DW-1:0] data1, data2, q1, q2, q2_s;
  logic          rom_clk1, rom_clk2;
  logic [AW-1:0] raddr1, raddr2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  font_rom_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .FNT_W(DW), .ROM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt1), .rsp_valid(vld1),
    .rsp_data(data1), .rom_clk(rom_clk1), .rom_addr(raddr1), .rom_q(q1)
  );

  font_rom_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .FNT_W(DW), .ROM_LAT(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt2), .rsp_valid(vld2),
    .rsp_data(data2), .rom_clk(rom_clk2), .rom_addr(raddr2), .rom_q(q2)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a ^ (a >> 3);
    return t[DW-1:0];
  endfunction

  always @(posedge rom_clk1) q1 <= rom_word(raddr1);
  always @(posedge rom_clk2) begin
    q2_s <= rom_word(raddr2);
    q2   <= q2_s;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [AW-1:0] a0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
    logic [AW-1:0] raddr;
    logic [3:0]    chk;   // {gnt, rsp_valid, rsp_data, rom_addr}
  } vec_t;

  function automatic vec_t v(input logic r, input logic [N-1:0] rq, input logic [AW-1:0] a0,
                             input logic [N-1:0] g, input logic [N-1:0] vl, input logic [DW-1:0] d,
                             input logic [AW-1:0] ra, input logic [3:0] c);
    vec_t x;
    x.rst = r; x.req = rq; x.a0 = a0; x.gnt = g; x.vld = vl; x.data = d; x.raddr = ra; x.chk = c;
    return x;
  endfunction

  vec_t tbl [26];

  logic [N-1:0]  s6_req [8];
  logic [AW-1:0] s6_a0  [8];
  logic [N-1:0]  s6_gnt [8];
  logic [N-1:0]  s6_v1  [8];
  logic [DW-1:0] s6_d1  [8];
  logic [N-1:0]  s6_v2  [8];
  logic [DW-1:0] s6_d2  [8];

  initial begin
    // Reset held with all requests up, then back-to-back display fetches of 5 and 21.
    tbl[0]  = v(1, 3'b111, 7'd5,  3'b000, 3'b000, 4'd0,  7'd0,  4'b1101);
    tbl[1]  = v(1, 3'b111, 7'd5,  3'b000, 3'b000, 4'd0,  7'd0,  4'b1101);
    tbl[2]  = v(1, 3'b111, 7'd5,  3'b000, 3'b000, 4'd0,  7'd0,  4'b1101);
    tbl[3]  = v(0, 3'b111, 7'd5,  3'b001, 3'b000, 4'd0,  7'd0,  4'b1101);
    tbl[4]  = v(0, 3'b001, 7'd21, 3'b001, 3'b000, 4'd0,  7'd5,  4'b1101);
    tbl[5]  = v(0, 3'b000, 7'd21, 3'b000, 3'b000, 4'd0,  7'd21, 4'b1101);
    tbl[6]  = v(0, 3'b000, 7'd21, 3'b000, 3'b001, 4'd5,  7'd21, 4'b1111);
    tbl[7]  = v(0, 3'b000, 7'd21, 3'b000, 3'b001, 4'd7,  7'd21, 4'b1111);
    tbl[8]  = v(0, 3'b000, 7'd21, 3'b000, 3'b000, 4'd0,  7'd21, 4'b1101);
    // All three requesting: display wins every cycle.
    tbl[9]  = v(0, 3'b111, 7'd1,  3'b001, 3'b000, 4'd0,  7'd21, 4'b1101);
    tbl[10] = v(0, 3'b111, 7'd1,  3'b001, 3'b000, 4'd0,  7'd1,  4'b1101);
    tbl[11] = v(0, 3'b111, 7'd1,  3'b001, 3'b000, 4'd0,  7'd1,  4'b1101);
    tbl[12] = v(0, 3'b111, 7'd1,  3'b001, 3'b001, 4'd1,  7'd1,  4'b1111);
`ifdef FONT_ARB_RR_EN
    tbl[13] = v(0, 3'b110, 7'd1,  3'b010, 3'b001, 4'd1,  7'd1,  4'b1111);
    tbl[14] = v(0, 3'b110, 7'd1,  3'b100, 3'b001, 4'd1,  7'd9,  4'b1111);
    tbl[15] = v(0, 3'b110, 7'd1,  3'b010, 3'b001, 4'd1,  7'd12, 4'b1111);
    tbl[16] = v(0, 3'b110, 7'd1,  3'b100, 3'b010, 4'd8,  7'd9,  4'b1111);
    tbl[17] = v(0, 3'b000, 7'd1,  3'b000, 3'b100, 4'd13, 7'd12, 4'b1111);
    tbl[18] = v(0, 3'b000, 7'd1,  3'b000, 3'b010, 4'd8,  7'd12, 4'b1111);
    tbl[19] = v(0, 3'b000, 7'd1,  3'b000, 3'b100, 4'd13, 7'd12, 4'b1111);
`else
    tbl[13] = v(0, 3'b110, 7'd1,  3'b010, 3'b001, 4'd1,  7'd1,  4'b1111);
    tbl[14] = v(0, 3'b110, 7'd1,  3'b010, 3'b001, 4'd1,  7'd9,  4'b1111);
    tbl[15] = v(0, 3'b110, 7'd1,  3'b010, 3'b001, 4'd1,  7'd9,  4'b1111);
    tbl[16] = v(0, 3'b110, 7'd1,  3'b010, 3'b010, 4'd8,  7'd9,  4'b1111);
    tbl[17] = v(0, 3'b000, 7'd1,  3'b000, 3'b010, 4'd8,  7'd9,  4'b1111);
    tbl[18] = v(0, 3'b000, 7'd1,  3'b000, 3'b010, 4'd8,  7'd9,  4'b1111);
    tbl[19] = v(0, 3'b000, 7'd1,  3'b000, 3'b010, 4'd8,  7'd9,  4'b1111);
`endif
    // Client 2 requests while the display is busy, then withdraws.
    tbl[20] = v(0, 3'b101, 7'd2,  3'b001, 3'b000, 4'd0,  7'd0,  4'b1100);
    tbl[21] = v(0, 3'b001, 7'd2,  3'b001, 3'b000, 4'd0,  7'd2,  4'b1101);
    tbl[22] = v(0, 3'b000, 7'd2,  3'b000, 3'b000, 4'd0,  7'd2,  4'b1101);
    tbl[23] = v(0, 3'b000, 7'd2,  3'b000, 3'b001, 4'd2,  7'd2,  4'b1111);
    tbl[24] = v(0, 3'b000, 7'd2,  3'b000, 3'b001, 4'd2,  7'd2,  4'b1111);
    tbl[25] = v(0, 3'b000, 7'd2,  3'b000, 3'b000, 4'd0,  7'd2,  4'b1101);

    s6_req = '{3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    s6_a0  = '{7'd3, 7'd3, 7'd21, 7'd21, 7'd21, 7'd21, 7'd21, 7'd21};
    s6_gnt = '{3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    s6_v1  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000, 3'b000};
    s6_d1  = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd8, 4'd7, 4'd0, 4'd0};
    s6_v2  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000};
    s6_d2  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd8, 4'd7, 4'd0};

    rst = 1'b1;
    req = 3'b111;
    addr[0] = 7'd5; addr[1] = 7'd9; addr[2] = 7'd12;
    next_cycle();

    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      addr[0] = tbl[i].a0;
      @(negedge clk);
      if (tbl[i].chk[3]) begin
        check($sformatf("row%0d gnt", i), 32'(gnt1), 32'(tbl[i].gnt));
        check($sformatf("row%0d gnt_l2", i), 32'(gnt2), 32'(tbl[i].gnt));
      end
      if (tbl[i].chk[2]) check($sformatf("row%0d rsp_valid", i), 32'(vld1), 32'(tbl[i].vld));
      if (tbl[i].chk[1]) check($sformatf("row%0d rsp_data", i), 32'(data1), 32'(tbl[i].data));
      if (tbl[i].chk[0]) check($sformatf("row%0d rom_addr", i), 32'(raddr1), 32'(tbl[i].raddr));
      $display("row %0d rst=%b req=%b gnt=%b rsp_valid=%b rsp_data=%h rom_addr=%0d",
               i, rst, req, gnt1, vld1, data1, raddr1);
      next_cycle();
    end

    // Grant client 1, then reset in the cycle before its response is due.
    rst = 1'b0; req = 3'b010; addr[1] = 7'd9;
    @(negedge clk);
    check("rst_mid grant", 32'(gnt1), 32'(3'b010));
    $display("rst_mid grant gnt=%b", gnt1);
    next_cycle();
    req = 3'b000;
    next_cycle();
    rst = 1'b1; req = 3'b010;
    @(negedge clk);
    check("rst_mid gnt_forced", 32'(gnt1), 32'(3'b000));
    check("rst_mid vld_in_rst", 32'(vld1), 32'(3'b000));
    $display("rst_mid in reset gnt=%b rsp_valid=%b", gnt1, vld1);
    next_cycle();
    rst = 1'b0; req = 3'b000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid vld c%0d", k), 32'(vld1), 32'(3'b000));
      check($sformatf("rst_mid vld_l2 c%0d", k), 32'(vld2), 32'(3'b000));
      $display("rst_mid after k=%0d rsp_valid=%b rsp_valid_l2=%b", k, vld1, vld2);
      next_cycle();
    end

    // Alternating grants 0,1,0 observed on both latencies.
    addr[1] = 7'd9;
    for (int k = 0; k < 8; k++) begin
      req = s6_req[k];
      addr[0] = s6_a0[k];
      @(negedge clk);
      check($sformatf("alt gnt c%0d", k), 32'(gnt1), 32'(s6_gnt[k]));
      check($sformatf("alt vld c%0d", k), 32'(vld1), 32'(s6_v1[k]));
      check($sformatf("alt vld_l2 c%0d", k), 32'(vld2), 32'(s6_v2[k]));
      if (s6_v1[k] != 3'b000) check($sformatf("alt data c%0d", k), 32'(data1), 32'(s6_d1[k]));
      if (s6_v2[k] != 3'b000) check($sformatf("alt data_l2 c%0d", k), 32'(data2), 32'(s6_d2[k]));
      $display("alt k=%0d gnt=%b rsp_valid=%b/%b rsp_data=%h/%h", k, gnt1, vld1, vld2, data1, data2);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
